// File: rtl/debug_cmd_sequencer.sv
// Debug-bus initiator: expands one debug request into an ordered write/read/poll sequence
// and returns one completion. Define DBG_SEQ_TIMEOUT_EN to bound polling to POLL_LIMIT reads.
module debug_cmd_sequencer #(
  parameter int POLL_LIMIT  = 256,
  parameter int RSP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_reg,
  input  logic [31:0] req_data,
  output logic        done_valid,
  output logic [31:0] done_data,
  output logic        done_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_payload_wr,
  output logic [7:0]  cmd_payload_address,
  output logic [31:0] cmd_payload_data,
  input  logic [31:0] rsp_data,
  input  logic        resetOut
);

  localparam logic [2:0] OP_HALT        = 3'd0;
  localparam logic [2:0] OP_RESUME      = 3'd1;
  localparam logic [2:0] OP_STEP        = 3'd2;
  localparam logic [2:0] OP_READ_REG    = 3'd3;
  localparam logic [2:0] OP_INJECT      = 3'd4;
  localparam logic [2:0] OP_READ_STATUS = 3'd5;
  localparam logic [2:0] OP_RESET       = 3'd6;
  localparam logic [2:0] OP_ILLEGAL     = 3'd7;

  localparam logic [1:0] LAT_LAST = 2'(RSP_LATENCY - 1);

  if (RSP_LATENCY < 1 || RSP_LATENCY > 4 || POLL_LIMIT < 1 || POLL_LIMIT > 65535) begin : g_param_check
    $error("debug_cmd_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL_RD, POLL_CHK, RES_RD, RES_CAP, DONE
  } state_e;

  state_e      state_r;
  logic [2:0]  op_r;
  logic [31:0] status_r;
  logic [31:0] result_r;
  logic        err_r;
  logic        abort_r;
  logic        rd_wait_r;
  logic [1:0]  lat_cnt_r;
  logic        fire_s;
  logic        abort_now_s;
  logic        abort_any_s;
  logic        lat_done_s;
`ifdef DBG_SEQ_TIMEOUT_EN
  localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);
  logic [15:0] poll_cnt_r;
`endif

  // HALT/STEP wait for halted-and-idle; register access only needs the pipeline idle.
  function automatic logic poll_met(input logic [2:0] op, input logic [31:0] st);
    logic met;
    case (op)
      OP_HALT, OP_STEP: met = st[1] & ~st[2];
      default:          met = ~st[2];
    endcase
    return met;
  endfunction

  function automatic logic [31:0] first_word(input logic [2:0] op, input logic [4:0] rg,
                                             input logic [31:0] d);
    logic [31:0] w;
    case (op)
      OP_HALT:     w = 32'h0002_0000;
      OP_RESUME:   w = 32'h0200_0000;
      OP_STEP:     w = 32'h0200_0010;
      OP_READ_REG: w = {12'h000, rg, 3'b000, 5'd0, 7'h13};
      OP_INJECT:   w = d;
      OP_RESET:    w = 32'h0001_0000;
      default:     w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] first_addr(input logic [2:0] op);
    logic [7:0] a;
    case (op)
      OP_READ_REG, OP_INJECT: a = 8'h04;
      default:                a = 8'h00;
    endcase
    return a;
  endfunction

  assign fire_s      = cmd_valid & cmd_ready;
  assign abort_now_s = resetOut && (op_r != OP_RESET) &&
                       (state_r == POLL_RD || state_r == POLL_CHK || state_r == RES_RD);
  assign abort_any_s = abort_r | abort_now_s;
  assign lat_done_s  = (lat_cnt_r == LAT_LAST);

  // Sequencer FSM with registered request, bus and completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      req_ready           <= 1'b0;
      done_valid          <= 1'b0;
      done_data           <= 32'h0000_0000;
      done_err            <= 1'b0;
      cmd_valid           <= 1'b0;
      cmd_payload_wr      <= 1'b0;
      cmd_payload_address <= 8'h00;
      cmd_payload_data    <= 32'h0000_0000;
      op_r                <= 3'd0;
      status_r            <= 32'h0000_0000;
      result_r            <= 32'h0000_0000;
      err_r               <= 1'b0;
      abort_r             <= 1'b0;
      rd_wait_r           <= 1'b0;
      lat_cnt_r           <= 2'd0;
`ifdef DBG_SEQ_TIMEOUT_EN
      poll_cnt_r          <= 16'd0;
`endif
    end else begin
      done_valid <= 1'b0;
      if (abort_now_s) begin
        abort_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_r      <= req_op;
            result_r  <= 32'h0000_0000;
            err_r     <= 1'b0;
            abort_r   <= 1'b0;
            rd_wait_r <= 1'b0;
`ifdef DBG_SEQ_TIMEOUT_EN
            poll_cnt_r <= 16'd0;
`endif
            case (req_op)
              OP_READ_STATUS: state_r <= RES_RD;
              OP_ILLEGAL: begin
                err_r   <= 1'b1;
                state_r <= DONE;
              end
              default: begin
                cmd_valid           <= 1'b1;
                cmd_payload_wr      <= 1'b1;
                cmd_payload_address <= first_addr(req_op);
                cmd_payload_data    <= first_word(req_op, req_reg, req_data);
                state_r             <= WR_A;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR_A: begin
          if (fire_s) begin
            cmd_valid <= 1'b0;
            case (op_r)
              OP_HALT, OP_STEP, OP_READ_REG, OP_INJECT: state_r <= POLL_RD;
              OP_RESET: state_r <= WR_B;
              default:  state_r <= DONE;
            endcase
          end
        end
        WR_B: begin
          if (cmd_valid) begin
            if (fire_s) begin
              cmd_valid <= 1'b0;
              state_r   <= DONE;
            end
          end else begin
            cmd_valid           <= 1'b1;
            cmd_payload_wr      <= 1'b1;
            cmd_payload_address <= 8'h00;
            cmd_payload_data    <= 32'h0100_0000;
          end
        end
        POLL_RD: begin
          if (cmd_valid) begin
            if (fire_s) begin
              cmd_valid <= 1'b0;
              rd_wait_r <= 1'b1;
              lat_cnt_r <= 2'd0;
`ifdef DBG_SEQ_TIMEOUT_EN
              poll_cnt_r <= poll_cnt_r + 16'd1;
`endif
            end
          end else if (rd_wait_r) begin
            if (lat_done_s) begin
              status_r  <= rsp_data;
              rd_wait_r <= 1'b0;
              if (abort_any_s) begin
                err_r    <= 1'b1;
                result_r <= 32'h0000_0000;
                state_r  <= DONE;
              end else begin
                state_r <= POLL_CHK;
              end
            end else begin
              lat_cnt_r <= lat_cnt_r + 2'd1;
            end
          end else if (abort_any_s) begin
            err_r    <= 1'b1;
            result_r <= 32'h0000_0000;
            state_r  <= DONE;
          end else begin
            cmd_valid           <= 1'b1;
            cmd_payload_wr      <= 1'b0;
            cmd_payload_address <= 8'h00;
            cmd_payload_data    <= 32'h0000_0000;
          end
        end
        POLL_CHK: begin
          if (abort_any_s) begin
            err_r    <= 1'b1;
            result_r <= 32'h0000_0000;
            state_r  <= DONE;
          end else if (poll_met(op_r, status_r)) begin
            if (op_r == OP_READ_REG || op_r == OP_INJECT) begin
              state_r <= RES_RD;
            end else begin
              result_r <= status_r;
              state_r  <= DONE;
            end
`ifdef DBG_SEQ_TIMEOUT_EN
          end else if (poll_cnt_r >= POLL_MAX) begin
            err_r    <= 1'b1;
            result_r <= status_r;
            state_r  <= DONE;
`endif
          end else begin
            state_r <= POLL_RD;
          end
        end
        RES_RD: begin
          if (cmd_valid) begin
            if (fire_s) begin
              cmd_valid <= 1'b0;
              lat_cnt_r <= 2'd0;
              state_r   <= RES_CAP;
            end
          end else if (abort_any_s) begin
            err_r    <= 1'b1;
            result_r <= 32'h0000_0000;
            state_r  <= DONE;
          end else begin
            cmd_valid           <= 1'b1;
            cmd_payload_wr      <= 1'b0;
            cmd_payload_address <= (op_r == OP_READ_STATUS) ? 8'h00 : 8'h04;
            cmd_payload_data    <= 32'h0000_0000;
          end
        end
        RES_CAP: begin
          if (lat_done_s) begin
            if (abort_any_s) begin
              err_r    <= 1'b1;
              result_r <= 32'h0000_0000;
            end else begin
              result_r <= rsp_data;
            end
            state_r <= DONE;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        DONE: begin
          done_valid <= 1'b1;
          done_data  <= result_r;
          done_err   <= err_r;
          state_r    <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed bench for debug_cmd_sequencer: vector table of whole ops plus hand-written
// sequences for latency, back-pressure, reset abort, resetOut abort and poll timeout.
module tb_debug_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [4:0]  req_reg = 5'd0;
  logic [31:0] req_data = 32'h0;
  logic        done_valid;
  logic [31:0] done_data;
  logic        done_err;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_payload_wr;
  logic [7:0]  cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [31:0] rsp_data = 32'hBAD0_BAD0;
  logic        resetOut = 1'b0;

  debug_cmd_sequencer #(.POLL_LIMIT(4), .RSP_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_reg(req_reg), .req_data(req_data),
    .done_valid(done_valid), .done_data(done_data), .done_err(done_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_wr(cmd_payload_wr),
    .cmd_payload_address(cmd_payload_address), .cmd_payload_data(cmd_payload_data),
    .rsp_data(rsp_data), .resetOut(resetOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rg;
    logic [31:0] data;
    logic [31:0] st0, st1, st2;
    int          nst;
    logic [31:0] res;
    int          ncmd;
    logic        f_wr;
    logic [7:0]  f_addr;
    logic [31:0] f_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  cmd_t        cmd_log[$];
  logic [31:0] status_q[$];
  logic [31:0] res_val = 32'h0;
  int          stab_err = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        hold_r = 1'b0;
  cmd_t        held_r;

  // Bus responder and monitor: logs fires, returns read data one cycle after a read fire.
  always @(posedge clk) begin
    logic [31:0] v;
    if (hold_r && !reset && (!cmd_valid || {cmd_payload_wr, cmd_payload_address, cmd_payload_data} != held_r))
      stab_err++;
    hold_r = cmd_valid && !cmd_ready && !reset;
    held_r = {cmd_payload_wr, cmd_payload_address, cmd_payload_data};
    if (done_valid) done_cnt++;
    if (!reset && cmd_valid && cmd_ready) begin
      cmd_log.push_back({cmd_payload_wr, cmd_payload_address, cmd_payload_data});
      if (!cmd_payload_wr) begin
        if (cmd_payload_address == 8'h04) v = res_val;
        else if (status_q.size() > 1) v = status_q.pop_front();
        else if (status_q.size() == 1) v = status_q[0];
        else v = 32'h0;
        rsp_data <= v;
      end else begin
        rsp_data <= 32'hBAD0_BAD0;
      end
    end else begin
      rsp_data <= 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rg, input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_send", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_reg = rg; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] d, output logic e);
    logic ok = 1'b0;
    d = 32'hFFFF_FFFF; e = 1'bx;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (done_valid) begin
        ok = 1'b1; d = done_data; e = done_err;
      end else begin
        @(negedge clk);
      end
    end
    check("done_seen", {31'd0, ok}, 32'd1);
  endtask

  vec_t        vecs[8];
  logic [31:0] d;
  logic        e;
  int          dc0;

  initial begin
    vecs[0] = '{3'd0, 5'd0, 32'h0, 32'h4, 32'h6, 32'h2, 3, 32'h0, 4, 1'b1, 8'h00, 32'h0002_0000, 32'h2, 1'b0};
    vecs[1] = '{3'd1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1, 1'b1, 8'h00, 32'h0200_0000, 32'h0, 1'b0};
    vecs[2] = '{3'd2, 5'd0, 32'h0, 32'h6, 32'h2, 32'h0, 2, 32'h0, 3, 1'b1, 8'h00, 32'h0200_0010, 32'h2, 1'b0};
    vecs[3] = '{3'd3, 5'd5, 32'h0, 32'h4, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 4, 1'b1, 8'h04, 32'h0002_8013, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{3'd4, 5'd0, 32'h0010_0093, 32'h0, 32'h0, 32'h0, 1, 32'h1234_5678, 3, 1'b1, 8'h04, 32'h0010_0093, 32'h1234_5678, 1'b0};
    vecs[5] = '{3'd5, 5'd0, 32'h0, 32'hA5, 32'h0, 32'h0, 1, 32'h0, 1, 1'b0, 8'h00, 32'h0, 32'hA5, 1'b0};
    vecs[6] = '{3'd6, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2, 1'b1, 8'h00, 32'h0001_0000, 32'h0, 1'b0};
    vecs[7] = '{3'd7, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_done_data", done_data, 32'h0);
    check("rst_done_err", {31'd0, done_err}, 32'd0);
    check("rst_payload", {cmd_payload_data[22:0], cmd_payload_address, cmd_payload_wr}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      cmd_ready = 1'b1;
      status_q.delete();
      if (vecs[i].nst > 0) status_q.push_back(vecs[i].st0);
      if (vecs[i].nst > 1) status_q.push_back(vecs[i].st1);
      if (vecs[i].nst > 2) status_q.push_back(vecs[i].st2);
      res_val = vecs[i].res;
      cmd_log.delete();
      send(vecs[i].op, vecs[i].rg, vecs[i].data);
      wait_done(d, e);
      check($sformatf("v%0d_done_data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d_done_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_cmd_count", i), cmd_log.size(), vecs[i].ncmd);
      if (vecs[i].ncmd > 0 && cmd_log.size() > 0) begin
        check($sformatf("v%0d_first_wr", i), {31'd0, cmd_log[0].wr}, {31'd0, vecs[i].f_wr});
        check($sformatf("v%0d_first_addr", i), {24'd0, cmd_log[0].addr}, {24'd0, vecs[i].f_addr});
        check($sformatf("v%0d_first_data", i), cmd_log[0].data, vecs[i].f_data);
      end
      @(negedge clk);
      check($sformatf("v%0d_pulse_len", i), {31'd0, done_valid}, 32'd0);
    end

    // RESUME latency floor and req_ready release
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("lat_c1_ready", {31'd0, req_ready}, 32'd0);
    check("lat_c1_done", {31'd0, done_valid}, 32'd0);
    @(negedge clk);
    check("lat_c2_done", {31'd0, done_valid}, 32'd0);
    @(negedge clk);
    check("lat_c3_done", {31'd0, done_valid}, 32'd1);
    check("lat_c3_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("lat_c4_ready", {31'd0, req_ready}, 32'd1);

    // RESET op under back-pressure
    cmd_ready = 1'b0;
    cmd_log.delete();
    stab_err = 0;
    dc0 = done_cnt;
    send(3'd6, 5'd0, 32'h0);
    repeat (5) @(negedge clk);
    check("bp_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("bp_payload", cmd_payload_data, 32'h0001_0000);
    check("bp_no_fire", cmd_log.size(), 0);
    cmd_ready = 1'b1;
    wait_done(d, e);
    @(negedge clk);
    check("bp_cmd_count", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      check("bp_wr0", cmd_log[0].data, 32'h0001_0000);
      check("bp_wr1", cmd_log[1].data, 32'h0100_0000);
    end
    check("bp_stable", stab_err, 0);
    check("bp_one_done", done_cnt - dc0, 1);

    // reset mid-poll aborts without completion
    status_q.delete(); status_q.push_back(32'h4);
    send(3'd0, 5'd0, 32'h0);
    repeat (6) @(negedge clk);
    dc0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt, dc0);
    status_q.delete(); status_q.push_back(32'h1357_9BDF);
    send(3'd5, 5'd0, 32'h0);
    wait_done(d, e);
    check("post_rst_status", d, 32'h1357_9BDF);
    check("post_rst_err", {31'd0, e}, 32'd0);

    // resetOut during polling
    status_q.delete(); status_q.push_back(32'h4);
    send(3'd0, 5'd0, 32'h0);
    repeat (6) @(negedge clk);
    resetOut = 1'b1;
    wait_done(d, e);
    resetOut = 1'b0;
    check("rstout_err", {31'd0, e}, 32'd1);
    check("rstout_data", d, 32'h0);

`ifdef DBG_SEQ_TIMEOUT_EN
    status_q.delete(); status_q.push_back(32'h4);
    cmd_log.delete();
    send(3'd0, 5'd0, 32'h0);
    wait_done(d, e);
    check("tmo_err", {31'd0, e}, 32'd1);
    check("tmo_data", d, 32'h4);
    check("tmo_cmds", cmd_log.size(), 5);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sequencer.md
Name: debug_cmd_sequencer

Overview:
- Initiator (driver) end of the core debug bus: converts single high-level debug requests into ordered debug-bus write/read/poll sequences.
- Ops: halt, resume, single-step, register read, raw instruction injection, status read, core reset.
- Sits between the test or host controller and the debug port of the VexRiscv core.
- Returns one completion per request, carrying result data and an error flag.

Parameters:
- POLL_LIMIT, 256: maximum status-read polls per op before timeout. Only used with DBG_SEQ_TIMEOUT_EN.
- RSP_LATENCY, 1: cycles from read-command fire to valid rsp_data. Legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer idle, request accepted on req_valid&req_ready
- req_op  in  3  0=HALT 1=RESUME 2=STEP 3=READ_REG 4=INJECT 5=READ_STATUS 6=RESET; 7 illegal
- req_reg  in  5  register index for READ_REG
- req_data  in  32  instruction word for INJECT
- done_valid  out  1  one-cycle completion pulse
- done_data  out  32  result or status word
- done_err  out  1  illegal op, timeout, or unexpected resetOut
- cmd_valid  out  1  debug-bus command valid
- cmd_ready  in  1  debug-bus command ready
- cmd_payload_wr  out  1  1=write, 0=read
- cmd_payload_address  out  8  0x00=control/status, 0x04=inject/result
- cmd_payload_data  out  32  write data
- rsp_data  in  32  read data
- resetOut  in  1  core reset request from debug logic

Behaviour:
- Interface: one clock `clk`; reset `reset`, synchronous, active-high.
- Reset values: req_ready=0 in the reset cycle, 1 from the next cycle (IDLE). All other outputs 0: done_valid, done_data, done_err, cmd_valid, cmd_payload_*. Reset mid-sequence aborts with no completion pulse.
- Request capture: op, reg and data are latched on acceptance. req_ready=0 from acceptance until the cycle after done_valid.
- Bus handshake:
  - Command fires on cmd_valid&cmd_ready.
  - cmd_valid and all payload stay stable until fire; cmd_valid drops in the cycle after fire.
  - At most one outstanding command.
- Read data: sampled exactly RSP_LATENCY cycles after read fire. No new command is issued before that sample.
- Control write encoding (addr 0x00):
  - bit16 set resetIt, bit24 clear resetIt
  - bit17 set haltIt, bit25 clear haltIt
  - bit4 stepIt
- Status read bits (addr 0x00): [0] resetIt, [1] haltIt, [2] pipBusy, [3] haltedByBreak, [4] stepIt.
- FSM states: IDLE, WR_A, WR_B, POLL_RD, POLL_CHK, RES_RD, RES_CAP, DONE.
- Op sequences:
  - HALT: WR_A(0x00, 0x0002_0000), then POLL until status[1]=1 && status[2]=0. done_data=final status.
  - RESUME: WR_A(0x00, 0x0200_0000), then DONE. done_data=0.
  - STEP: WR_A(0x00, 0x0200_0010), then POLL (same condition as HALT). done_data=final status.
  - READ_REG: WR_A(0x04, {12'h000, req_reg, 3'b000, 5'd0, 7'h13}) (addi x0,xN,0). POLL until status[2]=0. Then RES_RD read of 0x04. done_data=rsp_data.
  - INJECT: same as READ_REG with instruction=req_data.
  - READ_STATUS: single read of 0x00. done_data=rsp_data.
  - RESET: WR_A(0x00, 0x0001_0000), then WR_B(0x00, 0x0100_0000), then DONE. done_data=0.
  - op 7: DONE with done_err=1 and no bus traffic.
- DONE: done_valid high exactly 1 cycle, then IDLE. done_data/done_err hold until the next done_valid.
- Polling: each poll issues a fresh read of 0x00. POLL_CHK evaluates the sampled status one cycle later and re-polls if the condition is unmet.
- resetOut=1 observed in POLL_RD/POLL_CHK/RES_RD during any op except RESET: finish any outstanding bus handshake, then DONE with done_err=1 and done_data=0.
- Latency floor (cmd_ready=1, RSP_LATENCY=1): RESUME done_valid 3 cycles after acceptance.

Optional Feature:
- Macro: DBG_SEQ_TIMEOUT_EN.
- Defined: a 16-bit poll counter clears on request acceptance and increments per poll read fire. When it reaches POLL_LIMIT with the condition still unmet: DONE with done_err=1 and done_data=last status.
- Undefined: no counter; polling is unbounded and done_err arises only from an illegal op or resetOut.

Test Plan:
- HALT, cmd_ready=1. Status sequence 0x0000_0004, 0x0000_0006, 0x0000_0002 -> exactly one write (0x00, 0x0002_0000), three polls, done_data=0x0000_0002, done_err=0.
- READ_REG req_reg=5, result 0xDEAD_BEEF -> write (0x04, 0x0002_8013), poll, read 0x04, done_data=0xDEAD_BEEF.
- cmd_ready held low for 5 cycles during RESET op -> payload stable throughout, writes 0x0001_0000 then 0x0100_0000 in order, one done_valid.
- req_op=7 -> no cmd_valid, done_valid with done_err=1 the cycle after DONE entry.
- DBG_SEQ_TIMEOUT_EN, POLL_LIMIT=4, status stuck at 0x0000_0004 -> exactly 4 poll reads, done_err=1, done_data=0x0000_0004.
- reset asserted mid-poll, then READ_STATUS -> no done_valid for the aborted op; new op returns rsp_data unchanged.
